can_init_sequencer: RTL

- Power-up/re-init sequencer for the Canakari CAN controller register file.
- Steps through a fixed ordered list of register addresses and drives each one onto the init-data lookup block's address input.
- Takes the returned 16-bit init word, writes it over the Canakari register bus, and optionally reads it back to verify.
- Sits between bus-controller start logic (upstream) and the Canakari register port (downstream); interrupt-enable is always written last.

---
 rtl/can_init_sequencer_if.sv | 28 ++
 rtl/can_init_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/can_init_sequencer_if.sv
// Bundles the sequencer's control handshake, init-data lookup port and
// Canakari register bus. The sequencer drives it as master.
interface can_init_sequencer_if;
   logic        start;
   logic        busy;
   logic        done;
   logic        error;
   logic [4:0]  fail_addr;
   logic [4:0]  init_addr;
   logic [15:0] init_data;
   logic [4:0]  can_addr;
   logic [15:0] can_wdata;
   logic        can_write;
   logic        can_read;
   logic [15:0] can_rdata;

   modport master (
      input  start, init_data, can_rdata,
      output busy, done, error, fail_addr, init_addr,
             can_addr, can_wdata, can_write, can_read
   );

   modport slave (
      output start, init_data, can_rdata,
      input  busy, done, error, fail_addr, init_addr,
             can_addr, can_wdata, can_write, can_read
   );
endinterface

// File: rtl/can_init_sequencer.sv
// Power-up/re-init sequencer: writes the fixed Canakari register list from the
// init-data lookup, optionally verifying each write with masked readback.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_LOAD  | latch init_addr/init_data onto the register bus
// S_WRITE | can_write held for WR_HOLD cycles
// S_READ  | can_read for one cycle
// S_CHECK | masked compare of can_rdata against can_wdata
// S_DONE  | sequence finished cleanly, done held
// S_ERROR | register failed after all retries, error/fail_addr held
module can_init_sequencer #(
   parameter int WR_HOLD   = 2,
   parameter bit VERIFY_EN = 1'b1,
   parameter int MAX_RETRY = 2
) (
   input logic               clk,
   input logic               rst,
   can_init_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WRITE, S_READ, S_CHECK, S_DONE, S_ERROR
   } state_t;

   localparam logic [2:0] HOLD_INIT = 3'(WR_HOLD - 1);
   localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);
   localparam logic [2:0] LAST_IDX  = 3'd6;

   state_t      state, state_nx;
   logic [2:0]  idx, idx_nx;
   logic [1:0]  retry, retry_nx;
   logic [2:0]  hold, hold_nx;
   logic [4:0]  init_addr, init_addr_nx;
   logic [4:0]  can_addr, can_addr_nx;
   logic [15:0] can_wdata, can_wdata_nx;
   logic        done, done_nx;
   logic        error, error_nx;
   logic [4:0]  fail_addr, fail_addr_nx;
   logic        advance;

   function automatic logic [4:0] addr_of(input logic [2:0] i);
      case (i)
         3'd0:    addr_of = 5'h0F;
         3'd1:    addr_of = 5'h0E;
         3'd2:    addr_of = 5'h05;
         3'd3:    addr_of = 5'h04;
         3'd4:    addr_of = 5'h11;
         3'd5:    addr_of = 5'h10;
         default: addr_of = 5'h12;
      endcase
   endfunction

   // Interrupt/enable has reserved bits that may read back arbitrarily.
   function automatic logic [15:0] mask_of(input logic [4:0] a);
      mask_of = (a == 5'h12) ? 16'h8070 : 16'hFFFF;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         retry     <= '0;
         hold      <= '0;
         init_addr <= '0;
         can_addr  <= '0;
         can_wdata <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
         fail_addr <= '0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         retry     <= retry_nx;
         hold      <= hold_nx;
         init_addr <= init_addr_nx;
         can_addr  <= can_addr_nx;
         can_wdata <= can_wdata_nx;
         done      <= done_nx;
         error     <= error_nx;
         fail_addr <= fail_addr_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      retry_nx     = retry;
      hold_nx      = hold;
      init_addr_nx = init_addr;
      can_addr_nx  = can_addr;
      can_wdata_nx = can_wdata;
      done_nx      = done;
      error_nx     = error;
      fail_addr_nx = fail_addr;
      advance      = 1'b0;

      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (bus.start) begin
               state_nx     = S_LOAD;
               idx_nx       = '0;
               retry_nx     = '0;
               done_nx      = 1'b0;
               error_nx     = 1'b0;
               fail_addr_nx = '0;
               init_addr_nx = addr_of(3'd0);
            end
         end
         S_LOAD: begin
            can_addr_nx  = init_addr;
            can_wdata_nx = bus.init_data;
            hold_nx      = HOLD_INIT;
            state_nx     = S_WRITE;
         end
         S_WRITE: begin
            if (hold == 3'd0) begin
               if (VERIFY_EN) state_nx = S_READ;
               else           advance  = 1'b1;
            end else begin
               hold_nx = hold - 3'd1;
            end
         end
         S_READ: state_nx = S_CHECK;
         S_CHECK: begin
            if (((bus.can_rdata ^ can_wdata) & mask_of(can_addr)) == 16'h0000) begin
               advance = 1'b1;
            end else if (retry < RETRY_LIM) begin
               retry_nx = retry + 2'd1;
               hold_nx  = HOLD_INIT;
               state_nx = S_WRITE;
            end else begin
               error_nx     = 1'b1;
               fail_addr_nx = can_addr;
               state_nx     = S_ERROR;
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // Advancing shares the exit edge of WRITE/CHECK, so no extra cycle.
      if (advance) begin
         retry_nx = '0;
         if (idx == LAST_IDX) begin
            done_nx  = 1'b1;
            state_nx = S_DONE;
         end else begin
            idx_nx       = idx + 3'd1;
            init_addr_nx = addr_of(idx + 3'd1);
            state_nx     = S_LOAD;
         end
      end
   end

   assign bus.busy      = (state == S_LOAD) || (state == S_WRITE) ||
                          (state == S_READ) || (state == S_CHECK);
   assign bus.can_write = (state == S_WRITE);
   assign bus.can_read  = (state == S_READ);
   assign bus.init_addr = init_addr;
   assign bus.can_addr  = can_addr;
   assign bus.can_wdata = can_wdata;
   assign bus.done      = done;
   assign bus.error     = error;
   assign bus.fail_addr = fail_addr;

endmodule
